serial2parallel: RTL and testbench
==================================

Name: serial2parallel

Overview:
Serial-to-parallel deserializer that sits directly downstream of the parallel2serial stage. It consumes a qualified serial bit stream (data bit plus valid) and assembles WIDTH-bit words. Completed words are presented on a valid/ready output register, and an overflow pulse flags any word lost to backpressure. An optional sync input realigns word boundaries.

Parameters:
WIDTH, 4, word width in bits; legal values are WIDTH >= 2.
MSB_FIRST, 1, bit order. 1 means the first received bit lands in dout[WIDTH-1]. 0 means the first received bit lands in dout[0].

Ports:
clk  input  1  single clock; all logic is rising-edge.
rst_n  input  1  asynchronous active-low reset.
din  input  1  serial data bit.
din_valid  input  1  din is sampled on a rising edge only when this is 1.
sync  input  1  word-boundary realign (flush partial word).
dout  output  WIDTH  assembled parallel word.
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  downstream accepts dout when dout_valid & dout_ready.
overflow  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - shift register = 0, bit counter = 0.
  - dout = 0, dout_valid = 0, overflow = 0.
- Release of reset is sampled synchronously.
- Bit counter:
  - Width is $clog2(WIDTH); range 0..WIDTH-1.
  - Increments on each accepted bit (din_valid = 1).
  - Wraps to 0 after the WIDTH-th bit.
- Shift on an accepted bit:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], din}.
  - MSB_FIRST=0: shreg <= {din, shreg[WIDTH-1:1]}.
- din_valid = 0: the shift register and counter hold, and the partial word is retained indefinitely.
- Word completion is an accepted bit while counter == WIDTH-1.
  - The completed word is the shift result including the current bit.
  - The counter returns to 0.
- Output register load on completion:
  - If dout_valid = 0, or (dout_valid & dout_ready) in the same cycle: dout <= completed word and dout_valid <= 1.
  - Otherwise: the word is dropped, dout is unchanged, and overflow = 1 for exactly the next cycle.
- Latency: when the last bit is sampled at edge N, dout and dout_valid are visible after edge N. There are zero bubbles between the last bit and valid.
- Handshake:
  - dout_valid & dout_ready with no completion in the same cycle gives dout_valid <= 0.
  - dout keeps its last value after it is consumed; it is not cleared.
- dout and dout_valid never change while dout_valid=1 and dout_ready=0, except through reset.
- sync:
  - Clears the counter to 0 and discards the partial word.
  - sync with din_valid=1 in the same cycle: din is taken as bit 0 of a new word, and the counter becomes 1.
  - sync on the same edge as a would-be completion: sync wins, no word is produced, and overflow stays 0.
  - sync does not affect dout, dout_valid or a pending handshake.
- overflow is a registered single-cycle pulse. Back-to-back drops give back-to-back pulses.
- Reset mid-word or mid-handshake: all state is cleared and the pending word is lost. The first accepted bit after reset is bit 0 of a new word.
- Continuous streaming: with dout_ready held at 1, one word completes every WIDTH accepted bits and no overflow can occur.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, dout_ready=1; din_valid=1 with bits 1,0,1,1 on consecutive edges -> dout=4'hB and dout_valid=1 right after the 4th edge; dout_valid=0 one cycle later; overflow stays 0.
2. Same bits 1,1,0,0 with din_valid=0 gaps of 1–3 cycles between bits -> single word dout=4'hC; valid asserts only after the 4th accepted bit.
3. dout_ready=0; stream 4'hA then 4'h5 -> dout holds 4'hA with valid=1; overflow pulses one cycle after the 8th bit; raising ready drops valid next cycle and dout stays 4'hA.
4. Complete 4'hA with ready=0; raise ready on the same edge the next word 4'h5 completes -> dout=4'h5, valid stays 1 continuously, overflow=0.
5. Send bits 1,1, then sync=1 with din_valid=1 and din=0, then 1,1,0 -> dout=4'h6; no word is emitted for the flushed partial bits.
6. Assert rst_n low after 3 bits -> all outputs 0 immediately; after release, bits 1,0,0,0 with MSB_FIRST=0 -> dout=4'h1.

Source files
------------

// File: rtl/serial2parallel.sv
// Serial-to-parallel deserializer.
// Builds WIDTH-bit words from a qualified bit stream; valid/ready output.
module serial2parallel #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    cnt;
  logic             complete;
  logic             take;

  // Next shift value; sync starts the word from an empty register
  always_comb begin
    base = sync ? '0 : shreg;
    shift_nxt = base;
    if (MSB_FIRST)
      shift_nxt = {base[WIDTH-2:0], din};
    else
      shift_nxt = {din, base[WIDTH-1:1]};
    complete = din_valid && !sync && (cnt == LAST);
    take = !dout_valid || dout_ready;
  end

  // Shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (sync) begin
      shreg <= din_valid ? shift_nxt : '0;
      cnt   <= din_valid ? CW'(1) : '0;
    end else if (din_valid) begin
      shreg <= shift_nxt;
      cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Output register, handshake and overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (complete) begin
        if (take) begin
          dout       <= shift_nxt;
          dout_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench for serial2parallel.
// Two instances: MSB-first and LSB-first, same stimulus.
module tb_serial2parallel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic       dout_ready;
  logic [3:0] dout_m;
  logic       dv_m;
  logic       ovf_m;
  logic [3:0] dout_l;
  logic       dv_l;
  logic       ovf_l;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial2parallel #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .sync(sync), .dout(dout_m), .dout_valid(dv_m),
    .dout_ready(dout_ready), .overflow(ovf_m)
  );

  serial2parallel #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .sync(sync), .dout(dout_l), .dout_valid(dv_l),
    .dout_ready(dout_ready), .overflow(ovf_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_sync_bit(input logic b);
    din = b;
    din_valid = 1'b1;
    sync = 1'b1;
    tick();
    din_valid = 1'b0;
    sync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din = 1'b0;
    din_valid = 1'b0;
    sync = 1'b0;
    dout_ready = 1'b1;
    #12;
    total++;
    if ({dout_m, dv_m, ovf_m} !== 6'b0) begin
      bad++;
      $display("FAIL reset_state got %b want 000000",
               {dout_m, dv_m, ovf_m});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] v;
    logic       ov;
    v = 4'b1011;
    ov = 1'b0;
    dout_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      send_bit(v[i]);
      ov |= ovf_m;
      if (i > 0) begin
        total++;
        if (dv_m !== 1'b0) begin
          bad++;
          $display("FAIL basic_early_valid got %b want 0", dv_m);
        end
      end
    end
    total++;
    if (dv_m !== 1'b1 || dout_m !== 4'hB) begin
      bad++;
      $display("FAIL basic_word got %h/%b want b/1", dout_m, dv_m);
    end
    tick();
    ov |= ovf_m;
    total++;
    if (dv_m !== 1'b0 || ov !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain got v=%b ov=%b want 0/0", dv_m, ov);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] v;
    v = 4'b1100;
    dout_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      send_bit(v[i]);
      if (i > 0) begin
        total++;
        if (dv_m !== 1'b0) begin
          bad++;
          $display("FAIL gaps_early_valid got %b want 0", dv_m);
        end
        for (int g = 0; g < 4 - i; g++) tick();
        total++;
        if (dv_m !== 1'b0) begin
          bad++;
          $display("FAIL gaps_idle_valid got %b want 0", dv_m);
        end
      end
    end
    total++;
    if (dv_m !== 1'b1 || dout_m !== 4'hC) begin
      bad++;
      $display("FAIL gaps_word got %h/%b want c/1", dout_m, dv_m);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    v = 8'hA5;
    dout_ready = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (i == 4) begin
        total++;
        if (dv_m !== 1'b1 || dout_m !== 4'hA) begin
          bad++;
          $display("FAIL ovf_first got %h/%b want a/1", dout_m, dv_m);
        end
      end
    end
    total++;
    if (ovf_m !== 1'b1 || dout_m !== 4'hA || dv_m !== 1'b1) begin
      bad++;
      $display("FAIL ovf_pulse got o=%b d=%h v=%b want 1/a/1",
               ovf_m, dout_m, dv_m);
    end
    tick();
    total++;
    if (ovf_m !== 1'b0 || dv_m !== 1'b1) begin
      bad++;
      $display("FAIL ovf_end got o=%b v=%b want 0/1", ovf_m, dv_m);
    end
    dout_ready = 1'b1;
    tick();
    total++;
    if (dv_m !== 1'b0 || dout_m !== 4'hA) begin
      bad++;
      $display("FAIL ovf_consume got %h/%b want a/0", dout_m, dv_m);
    end
  endtask

  task automatic test_same_edge_ready();
    logic [7:0] v;
    logic       ov;
    v = 8'hA5;
    ov = 1'b0;
    dout_ready = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) dout_ready = 1'b1;
      send_bit(v[i]);
      ov |= ovf_m;
      if (i < 4) begin
        total++;
        if (dv_m !== 1'b1) begin
          bad++;
          $display("FAIL same_edge_valid got %b want 1", dv_m);
        end
      end
    end
    total++;
    if (dout_m !== 4'h5 || ov !== 1'b0) begin
      bad++;
      $display("FAIL same_edge_word got %h ov=%b want 5/0", dout_m, ov);
    end
    tick();
  endtask

  task automatic test_sync();
    dout_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_sync_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    total++;
    if (dv_m !== 1'b0) begin
      bad++;
      $display("FAIL sync_no_word got %b want 0", dv_m);
    end
    send_bit(1'b0);
    total++;
    if (dv_m !== 1'b1 || dout_m !== 4'h6) begin
      bad++;
      $display("FAIL sync_word got %h/%b want 6/1", dout_m, dv_m);
    end
    tick();
  endtask

  task automatic test_sync_completion();
    dout_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_sync_bit(1'b1);
    total++;
    if (dv_m !== 1'b0 || ovf_m !== 1'b0) begin
      bad++;
      $display("FAIL sync_win got v=%b o=%b want 0/0", dv_m, ovf_m);
    end
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    total++;
    if (dv_m !== 1'b1 || dout_m !== 4'h9) begin
      bad++;
      $display("FAIL sync_win_word got %h/%b want 9/1", dout_m, dv_m);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic       ov;
    v = 8'h3E;
    ov = 1'b0;
    dout_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      ov |= ovf_m;
      if (i == 4) begin
        total++;
        if (dv_m !== 1'b1 || dout_m !== 4'h3) begin
          bad++;
          $display("FAIL b2b_first got %h/%b want 3/1", dout_m, dv_m);
        end
      end
    end
    total++;
    if (dv_m !== 1'b1 || dout_m !== 4'hE || ov !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second got %h/%b ov=%b want e/1/0",
               dout_m, dv_m, ov);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dout_m, dv_m, ovf_m, dout_l, dv_l, ovf_l} !== 12'b0) begin
      bad++;
      $display("FAIL mid_reset got %h/%b/%b %h/%b/%b want zeros",
               dout_m, dv_m, ovf_m, dout_l, dv_l, ovf_l);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    tick();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    total++;
    if (dv_l !== 1'b1 || dout_l !== 4'h1) begin
      bad++;
      $display("FAIL lsb_word got %h/%b want 1/1", dout_l, dv_l);
    end
    total++;
    if (dv_m !== 1'b1 || dout_m !== 4'h8) begin
      bad++;
      $display("FAIL msb_after_reset got %h/%b want 8/1", dout_m, dv_m);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_same_edge_ready();
    test_sync();
    test_sync_completion();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
